// File: rtl/mc_control_unit_if.sv
// Control/status bundle between the multicycle control unit and the RV32I datapath.
// master = control unit side, slave = datapath side.
interface mc_control_unit_if #(
  parameter int ALU_CTRL_W = 4
);
  // Datapath -> control unit
  logic [6:0]            OP;
  logic [2:0]            funct3;
  logic                  funct7;
  logic                  Zero;
  logic                  Neg;
  logic                  Carry;
  logic                  Ovf;
  logic                  MemReady;

  // Control unit -> datapath
  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  IRWrite;
  logic                  RegWrite;
  logic                  MemWrite;
  logic                  MemReq;
  logic [1:0]            ResultSrc;
  logic [1:0]            ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic [2:0]            ImmSrc;
  logic                  Illegal;
  logic [3:0]            State;

  modport master (
    input  OP, funct3, funct7, Zero, Neg, Carry, Ovf, MemReady,
    output PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, MemReq,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, State
  );

  modport slave (
    output OP, funct3, funct7, Zero, Neg, Carry, Ovf, MemReady,
    input  PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, MemReq,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, State
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with memory-ready stalls, full branch evaluation and a sticky illegal-instruction trap.
module mc_control_unit #(
  parameter int ALU_CTRL_W = 4,
  parameter bit BRANCH_EXT = 1'b1
) (
  input logic               CLK,
  input logic               RST,
  mc_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_JALRLINK = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  state_t     state_reg;
  state_t     state_next;
  logic       branch_legal;
  logic       branch_taken;
  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       mem_req;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic [2:0] imm_src;
  logic       illegal_flag;

  function automatic logic [3:0] funct_alu(input logic [2:0] f3, input logic f7,
                                           input logic allow_sub);
    logic [3:0] code;
    case (f3)
      3'b000:  code = (allow_sub && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  // With the reduced branch set only BEQ is decoded; everything else traps.
  generate
    if (BRANCH_EXT) begin : g_full_branch
      assign branch_legal = (bus.funct3[2:1] != 2'b01);
    end else begin : g_beq_only
      assign branch_legal = (bus.funct3 == 3'b000);
    end
  endgenerate

  always_comb begin
    branch_taken = 1'b0;
    case (bus.funct3)
      3'b000:  branch_taken = bus.Zero;
      3'b001:  branch_taken = !bus.Zero;
      3'b100:  branch_taken = bus.Neg ^ bus.Ovf;
      3'b101:  branch_taken = !(bus.Neg ^ bus.Ovf);
      3'b110:  branch_taken = !bus.Carry;
      3'b111:  branch_taken = bus.Carry;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    imm_src = 3'b000;
    case (bus.OP)
      OP_LOAD, OP_ITYPE, OP_JALR: imm_src = 3'b000;
      OP_STORE:                   imm_src = 3'b001;
      OP_BRANCH:                  imm_src = 3'b010;
      OP_LUI, OP_AUIPC:           imm_src = 3'b011;
      OP_JAL:                     imm_src = 3'b100;
      default:                    imm_src = 3'b000;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_write     = 1'b0;
    adr_src      = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    mem_write    = 1'b0;
    mem_req      = 1'b0;
    result_src   = RES_ALUOUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALU_ADD;
    illegal_flag = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = bus.MemReady;
        pc_write   = bus.MemReady;
        if (bus.MemReady) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the PC-relative target into ALUOut for branches and JAL.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (bus.OP)
          OP_LOAD, OP_STORE: state_next = (bus.funct3 == 3'b010) ? S_MEMADR : S_TRAP;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_BRANCH:         state_next = branch_legal ? S_BRANCH : S_TRAP;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = (bus.OP == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (bus.MemReady) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = funct_alu(bus.funct3, bus.funct7, 1'b1);
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = funct_alu(bus.funct3, bus.funct7, 1'b0);
        state_next = S_ALUWB;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the link value is formed.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_SUB;
        pc_write   = branch_taken;
        state_next = S_FETCH;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        pc_write   = 1'b1;
        state_next = S_JALRLINK;
      end
      S_JALRLINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        alu_src_b  = SRCB_IMM;
        alu_op     = ALU_PASSB;
        state_next = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        state_next = S_ALUWB;
      end
      default: begin
        illegal_flag = 1'b1;
        state_next   = S_TRAP;
      end
    endcase

    // State is already FETCH while reset is held; only the enables need masking.
    if (!RST) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_req   = 1'b0;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.MemWrite   = mem_write;
  assign bus.MemReq     = mem_req;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = ALU_CTRL_W'(alu_op);
  assign bus.ImmSrc     = imm_src;
  assign bus.Illegal    = illegal_flag;
  assign bus.State      = state_reg;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: per-instruction expected control traces
// built from the instruction-level behaviour, run on full and BEQ-only variants.
module tb_mc_control_unit;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mc_control_unit_if #(.ALU_CTRL_W(4)) bus_ext ();
  mc_control_unit_if #(.ALU_CTRL_W(4)) bus_beq ();

  mc_control_unit #(.ALU_CTRL_W(4), .BRANCH_EXT(1'b1)) dut_ext (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_ext.master)
  );

  mc_control_unit #(.ALU_CTRL_W(4), .BRANCH_EXT(1'b0)) dut_beq (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_beq.master)
  );

  logic [6:0] op   = 7'd0;
  logic [2:0] f3   = 3'd0;
  logic       f7   = 1'b0;
  logic       zf   = 1'b0;
  logic       nf   = 1'b0;
  logic       cf   = 1'b0;
  logic       vf   = 1'b0;
  logic       mrdy = 1'b0;

  assign bus_ext.OP = op;   assign bus_ext.funct3 = f3; assign bus_ext.funct7 = f7;
  assign bus_ext.Zero = zf; assign bus_ext.Neg = nf;    assign bus_ext.Carry = cf;
  assign bus_ext.Ovf = vf;  assign bus_ext.MemReady = mrdy;
  assign bus_beq.OP = op;   assign bus_beq.funct3 = f3; assign bus_beq.funct7 = f7;
  assign bus_beq.Zero = zf; assign bus_beq.Neg = nf;    assign bus_beq.Carry = cf;
  assign bus_beq.Ovf = vf;  assign bus_beq.MemReady = mrdy;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, irw, rw, mw, mreq;
    logic [1:0] res, sa, sb;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       ill;
  } exp_t;

  logic [23:0] obs_ext, obs_beq;
  assign obs_ext = {bus_ext.State, bus_ext.PCWrite, bus_ext.AdrSrc, bus_ext.IRWrite,
                    bus_ext.RegWrite, bus_ext.MemWrite, bus_ext.MemReq, bus_ext.ResultSrc,
                    bus_ext.ALUSrcA, bus_ext.ALUSrcB, bus_ext.ALUControl, bus_ext.ImmSrc,
                    bus_ext.Illegal};
  assign obs_beq = {bus_beq.State, bus_beq.PCWrite, bus_beq.AdrSrc, bus_beq.IRWrite,
                    bus_beq.RegWrite, bus_beq.MemWrite, bus_beq.MemReq, bus_beq.ResultSrc,
                    bus_beq.ALUSrcA, bus_beq.ALUSrcB, bus_beq.ALUControl, bus_beq.ImmSrc,
                    bus_beq.Illegal};

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  bit   rdy_q[$];
  logic [2:0] cur_imm;

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
      7'b0100011:                         return 3'b001;
      7'b1100011:                         return 3'b010;
      7'b0110111, 7'b0010111:             return 3'b011;
      7'b1101111:                         return 3'b100;
      default:                            return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] fn3, input logic fn7, input bit is_r);
    case (fn3)
      3'd0:    return (is_r && fn7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd7;
      3'd2:    return 4'd5;
      3'd3:    return 4'd6;
      3'd4:    return 4'd4;
      3'd5:    return fn7 ? 4'd9 : 4'd8;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Branch outcome computed directly from the operand values.
  function automatic bit taken_of(input logic [2:0] fn3, input logic [31:0] a, input logic [31:0] b);
    case (fn3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t mk(input logic [3:0] st, input logic pcw, input logic adr,
                              input logic irw, input logic rw, input logic mw, input logic mreq,
                              input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [3:0] alu);
    exp_t e;
    e = '{st: st, pcw: pcw, adr: adr, irw: irw, rw: rw, mw: mw, mreq: mreq,
          res: res, sa: sa, sb: sb, alu: alu, imm: cur_imm, ill: (st == 4'd15)};
    return e;
  endfunction

  task automatic push(input exp_t e, input bit r);
    exp_q.push_back(e);
    rdy_q.push_back(r);
  endtask

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Builds the expected per-cycle trace of one instruction.
  task automatic model_instr(input logic [6:0] o, input logic [2:0] fn3, input logic fn7,
                             input logic [31:0] a, input logic [31:0] b,
                             input int fw, input int mw, input bit ext);
    bit is_load;
    bit legal;
    cur_imm = imm_of(o);
    is_load = (o == 7'b0000011);
    for (int i = 0; i < fw; i++) push(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 2, 0), 1'b0);
    push(mk(0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0), 1'b1);
    push(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), rnd());
    case (o)
      7'b0000011, 7'b0100011: begin
        if (fn3 != 3'd2) begin
          push(mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd());
        end else begin
          push(mk(2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0), rnd());
          for (int i = 0; i <= mw; i++)
            push(mk(is_load ? 4'd3 : 4'd5, 0, 1, 0, 0, !is_load, 1, 0, 0, 0, 0), i == mw);
          if (is_load) push(mk(4, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0), rnd());
        end
      end
      7'b0110011: begin
        push(mk(6, 0, 0, 0, 0, 0, 0, 0, 2, 0, alu_of(fn3, fn7, 1'b1)), rnd());
        push(mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), rnd());
      end
      7'b0010011: begin
        push(mk(8, 0, 0, 0, 0, 0, 0, 0, 2, 1, alu_of(fn3, fn7, 1'b0)), rnd());
        push(mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), rnd());
      end
      7'b1101111: begin
        push(mk(9, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0), rnd());
        push(mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), rnd());
      end
      7'b1100111: begin
        push(mk(11, 1, 0, 0, 0, 0, 0, 2, 2, 1, 0), rnd());
        push(mk(14, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0), rnd());
        push(mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), rnd());
      end
      7'b1100011: begin
        legal = ext ? (fn3 != 3'd2 && fn3 != 3'd3) : (fn3 == 3'd0);
        if (legal) push(mk(10, taken_of(fn3, a, b), 0, 0, 0, 0, 0, 0, 2, 0, 1), rnd());
        else       push(mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd());
      end
      7'b0110111: begin
        push(mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10), rnd());
        push(mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), rnd());
      end
      7'b0010111: begin
        push(mk(13, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), rnd());
        push(mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), rnd());
      end
      default: push(mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd());
    endcase
  endtask

  // Entry and exit at a falling edge; each step samples #1 after inputs settle.
  task automatic run_queue(input string name, input bit use_beq);
    exp_t        e;
    bit          r;
    logic [23:0] got;
    int          n;
    int          bad;
    n   = 0;
    bad = 0;
    while (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      r    = rdy_q.pop_front();
      mrdy = r;
      #1;
      got = use_beq ? obs_beq : obs_ext;
      checks++;
      if (got !== e) begin
        failures++;
        bad++;
        $display("FAIL %s step %0d: got state=%0d vec=%h, required state=%0d vec=%h",
                 name, n, got[23:20], got, e.st, e);
      end
      @(negedge CLK);
      n++;
    end
    $display("%s: op=%b f3=%b steps=%0d mismatches=%0d", name, op, f3, n, bad);
  endtask

  task automatic do_instr(input string name, input logic [6:0] o, input logic [2:0] fn3,
                          input logic fn7, input logic [31:0] a, input logic [31:0] b,
                          input int fw, input int mw, input bit use_beq);
    logic [31:0] diff;
    op   = o;
    f3   = fn3;
    f7   = fn7;
    diff = a - b;
    zf   = (a == b);
    nf   = diff[31];
    cf   = (a >= b);
    vf   = (a[31] != b[31]) && (diff[31] != a[31]);
    model_instr(o, fn3, fn7, a, b, fw, mw, !use_beq);
    run_queue(name, use_beq);
  endtask

  task automatic apply_reset();
    RST  = 1'b0;
    mrdy = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    op      = 7'b0110011;
    cur_imm = imm_of(op);
    RST     = 1'b0;
    mrdy    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      e = mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0);
      checks++;
      if (obs_ext !== e) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got %h, required %h", i, obs_ext, e);
      end
      @(negedge CLK);
    end
    RST = 1'b1;
    #1;
    e = mk(0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0);
    checks++;
    if (obs_ext !== e) begin
      failures++;
      $display("FAIL reset_release: got %h, required %h", obs_ext, e);
    end
    $display("reset: held 3 cycles, released into FETCH");
    @(negedge CLK);
  endtask

  task automatic test_rtype_sub();
    apply_reset();
    do_instr("rtype_sub", 7'b0110011, 3'd0, 1'b1, 32'd9, 32'd4, 0, 0, 1'b0);
  endtask

  task automatic test_lw_wait();
    apply_reset();
    do_instr("lw_wait2", 7'b0000011, 3'd2, 1'b0, 32'd0, 32'd0, 0, 2, 1'b0);
    do_instr("sw_wait1", 7'b0100011, 3'd2, 1'b0, 32'd0, 32'd0, 1, 1, 1'b0);
  endtask

  task automatic test_branches();
    apply_reset();
    do_instr("blt_taken",    7'b1100011, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd0, 0, 0, 1'b0);
    do_instr("bgeu_nottaken", 7'b1100011, 3'd7, 1'b0, 32'd1, 32'd2, 0, 0, 1'b0);
    do_instr("bne_taken",    7'b1100011, 3'd1, 1'b0, 32'd1, 32'd2, 0, 0, 1'b0);
    do_instr("beq_nottaken", 7'b1100011, 3'd0, 1'b0, 32'd5, 32'd6, 0, 0, 1'b0);
  endtask

  task automatic test_jalr();
    apply_reset();
    do_instr("jalr", 7'b1100111, 3'd0, 1'b0, 32'd0, 32'd0, 0, 0, 1'b0);
    do_instr("alu_after_jalr", 7'b0010011, 3'd5, 1'b1, 32'd0, 32'd0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [9];
    logic [2:0] bf3 [6];
    logic [6:0] o;
    logic [2:0] fn3;
    logic [31:0] a, b;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
            7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      o   = ops[$urandom_range(0, 8)];
      fn3 = 3'($urandom_range(0, 7));
      if (o == 7'b0000011 || o == 7'b0100011) fn3 = 3'd2;
      if (o == 7'b1100011) fn3 = bf3[$urandom_range(0, 5)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      do_instr($sformatf("rand%0d", i), o, fn3, 1'($urandom_range(0, 1)), a, b,
               $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    apply_reset();
    op = 7'b1111111;
    f3 = 3'd0;
    model_instr(7'b1111111, 3'd0, 1'b0, 32'd0, 32'd0, 0, 0, 1'b1);
    for (int i = 0; i < 9; i++) push(mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd());
    run_queue("illegal_op", 1'b0);
    RST  = 1'b0;
    mrdy = 1'b1;
    #1;
    e = mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0);
    checks++;
    if (obs_ext !== e) begin
      failures++;
      $display("FAIL trap_cleared: got %h, required %h", obs_ext, e);
    end
    @(negedge CLK);
    RST = 1'b1;
    do_instr("lui_after_trap", 7'b0110111, 3'd3, 1'b0, 32'd0, 32'd0, 0, 0, 1'b0);
    do_instr("lw_bad_f3", 7'b0000011, 3'd1, 1'b0, 32'd0, 32'd0, 0, 0, 1'b0);
  endtask

  task automatic test_branch_ext0();
    apply_reset();
    do_instr("beq_only_beq", 7'b1100011, 3'd0, 1'b0, 32'd7, 32'd7, 1, 0, 1'b1);
    do_instr("auipc_beq_only", 7'b0010111, 3'd0, 1'b0, 32'd0, 32'd0, 0, 0, 1'b1);
    op = 7'b1100011;
    f3 = 3'd1;
    model_instr(7'b1100011, 3'd1, 1'b0, 32'd1, 32'd2, 0, 0, 1'b0);
    push(mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rnd());
    run_queue("bne_beq_only", 1'b1);
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_rtype_sub();
    test_lw_wait();
    test_branches();
    test_jalr();
    test_back_to_back();
    test_illegal();
    test_branch_ext0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
